// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling, byte out with one-cycle valid/frame_err strobes.
// Strobe lands CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 2 cycles after the start edge; no backpressure, strobes are not held.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt, data_nxt;
  logic                 valid_nxt, err_nxt;

  // Both flops reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      data_out  <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= err_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          if (idx == IDX_LAST) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low break must release before another start is accepted.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed + random frames into three receivers (16, 4 and 434 clocks per bit), strobes scored against a frame-level model.
module tb_uart_rx_byte;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx16 = 1'b1, rx4 = 1'b1, rx434 = 1'b1;
  logic [7:0] dout16, dout4, dout434;
  logic v16, v4, v434, e16, e4, e434, b16, b4, b434;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         sel;
    int         t;
    logic [7:0] dat;
    logic [1:0] ve;
  } ev_t;

  ev_t        got[$];
  ev_t        exp_q[$];
  logic [7:0] exp_dout[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_byte #(.CLKS_PER_BIT(16), .DATA_BITS(8)) u16 (
    .clk(clk), .rst(rst), .rx(rx16), .data_out(dout16), .valid(v16), .frame_err(e16), .busy(b16));
  uart_rx_byte #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u4 (
    .clk(clk), .rst(rst), .rx(rx4), .data_out(dout4), .valid(v4), .frame_err(e4), .busy(b4));
  uart_rx_byte #(.CLKS_PER_BIT(434), .DATA_BITS(8)) u434 (
    .clk(clk), .rst(rst), .rx(rx434), .data_out(dout434), .valid(v434), .frame_err(e434), .busy(b434));

  function automatic ev_t mk_ev(input int sel, input int t, input logic [7:0] dat, input logic [1:0] ve);
    ev_t ev;
    ev.sel = sel;
    ev.t   = t;
    ev.dat = dat;
    ev.ve  = ve;
    return ev;
  endfunction

  always @(negedge clk) begin
    if (v16 || e16)   got.push_back(mk_ev(0, cyc, dout16, {v16, e16}));
    if (v4 || e4)     got.push_back(mk_ev(1, cyc, dout4, {v4, e4}));
    if (v434 || e434) got.push_back(mk_ev(2, cyc, dout434, {v434, e434}));
  end

  function automatic int cpb(input int sel);
    return (sel == 0) ? 16 : (sel == 1) ? 4 : 434;
  endfunction

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx16 = v;
      1:       rx4 = v;
      default: rx434 = v;
    endcase
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    set_rx(sel, v);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: a good frame strobes valid with its byte, a low stop bit strobes
  // frame_err with data_out untouched; both at t0 + 2 + cpb/2 + 9*cpb (+/-1).
  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit, input bit model);
    int c  = cpb(sel);
    int t0 = cyc + 1;
    if (model) begin
      if (stop_bit) exp_dout[sel] = b;
      exp_q.push_back(mk_ev(sel, t0 + 2 + c / 2 + 9 * c, exp_dout[sel], stop_bit ? 2'b10 : 2'b01));
    end
    hold(sel, 1'b0, c);
    for (int i = 0; i < 8; i++) hold(sel, b[i], c);
    hold(sel, stop_bit, c);
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    assert (act === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic check_events(input string tag);
    vectors++;
    assert (got.size() === exp_q.size()) else begin
      miscompares++;
      $error("FAIL %s strobe count: observed %0d expected %0d", tag, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      vectors++;
      assert ({got[i].sel, got[i].ve, got[i].dat} === {exp_q[i].sel, exp_q[i].ve, exp_q[i].dat}) else begin
        miscompares++;
        $error("FAIL %s ev%0d: observed inst%0d valid/err=%b data=%h expected inst%0d valid/err=%b data=%h",
               tag, i, got[i].sel, got[i].ve, got[i].dat, exp_q[i].sel, exp_q[i].ve, exp_q[i].dat);
      end
      vectors++;
      assert ((got[i].t >= exp_q[i].t - 1 && got[i].t <= exp_q[i].t + 1) === 1'b1) else begin
        miscompares++;
        $error("FAIL %s ev%0d latency: observed cycle %0d expected %0d +/-1", tag, i, got[i].t, exp_q[i].t);
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;

    // Reset state
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst data_out", 32'(dout16), 32'h0);
    chk("rst valid", 32'(v16), 32'h0);
    chk("rst frame_err", 32'(e16), 32'h0);
    chk("rst busy", 32'(b16), 32'h0);
    rst = 1'b0;
    hold(0, 1'b1, 2);
    chk("idle busy434", 32'(b434), 32'h0);

    // Single frame
    send_frame(0, 8'h55, 1'b1, 1'b1);
    hold(0, 1'b1, 12);
    check_events("single 0x55");
    chk("single nibble", 32'(dout16[3:0]), 32'h5);
    chk("single busy after", 32'(b16), 32'h0);

    // Back-to-back frames
    send_frame(0, 8'hA5, 1'b1, 1'b1);
    send_frame(0, 8'h0F, 1'b1, 1'b1);
    send_frame(0, 8'hF0, 1'b1, 1'b1);
    hold(0, 1'b1, 12);
    if (got.size() >= 3) begin
      chk("b2b spacing 1-2", 32'(got[1].t - got[0].t), 32'd160);
      chk("b2b spacing 2-3", 32'(got[2].t - got[1].t), 32'd160);
    end
    check_events("back-to-back");

    // False start
    hold(0, 1'b0, 3);
    chk("glitch busy rises", 32'(b16), 32'h1);
    hold(0, 1'b0, 1);
    hold(0, 1'b1, 8);
    chk("glitch busy cleared", 32'(b16), 32'h0);
    check_events("false start");
    chk("glitch data held", 32'(dout16), 32'(exp_dout[0]));

    // Framing error then held-low break
    send_frame(0, 8'h3C, 1'b1, 1'b1);
    send_frame(0, 8'h99, 1'b0, 1'b1);
    hold(0, 1'b0, 40);
    hold(0, 1'b1, 48);
    check_events("framing error");
    chk("ferr data held", 32'(dout16), 32'h3C);
    send_frame(0, 8'h12, 1'b1, 1'b1);
    hold(0, 1'b1, 12);
    check_events("after break 0x12");

    // Reset during data bit 4
    fork
      send_frame(0, 8'hFF, 1'b1, 1'b0);
      begin
        repeat (5 * 16 + 8) begin
          @(posedge clk);
          #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;
    hold(0, 1'b1, 12);
    check_events("reset mid-frame");
    chk("reset data_out", 32'(dout16), 32'h0);
    send_frame(0, 8'h5A, 1'b1, 1'b1);
    hold(0, 1'b1, 12);
    check_events("after reset 0x5A");

    // Random bytes with short random idle gaps
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(0, b, 1'b1, 1'b1);
      hold(0, 1'b1, int'($urandom_range(0, 3)));
    end
    hold(0, 1'b1, 12);
    check_events("random frames");
    chk("random last data", 32'(dout16), 32'(exp_dout[0]));

    // Parameter sweep
    send_frame(1, 8'h55, 1'b1, 1'b1);
    b = 8'($urandom_range(0, 255));
    send_frame(1, b, 1'b1, 1'b1);
    hold(1, 1'b1, 12);
    check_events("cpb4 frames");
    chk("cpb4 data", 32'(dout4), 32'(b));
    send_frame(2, 8'h55, 1'b1, 1'b1);
    hold(2, 1'b1, 20);
    check_events("cpb434 0x55");
    chk("cpb434 nibble", 32'(dout434[3:0]), 32'h5);
    chk("cpb434 busy after", 32'(b434), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Synchronous UART receiver that deserializes 8N1 frames from the asynchronous `rx` line into bytes. It sits directly upstream of the FSM pattern-detector stage. Each good frame produces the received byte on `data_out` with a one-cycle `valid` strobe, and the downstream detector consumes `data_out[3:0]`. Malformed frames raise `frame_err` and never update `data_out`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be an even integer ≥ 4.
- `DATA_BITS`, default 8: payload bits per frame, LSB first.

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: asynchronous serial line; idle high.
- `data_out`, out, `DATA_BITS`: last correctly received byte. Held until the next good frame.
- `valid`, out, 1: one-cycle pulse when `data_out` updates.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- Input synchronizer:
  - `rx` passes through a 2-flop synchronizer to form `rx_s`.
  - Both flops reset to 1 (line idle).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE:
    - On `rx_s == 0`, go to START and load the counter with 0.
  - START:
    - Count to `CLKS_PER_BIT/2 - 1` (mid start bit), then sample `rx_s`.
    - If `rx_s == 1`, the start was false: return to IDLE with no strobe.
    - If `rx_s == 0`, go to DATA with bit index 0 and counter 0.
  - DATA:
    - Every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit[index], LSB first.
    - After bit `DATA_BITS-1`, go to STOP.
  - STOP:
    - After `CLKS_PER_BIT` cycles, sample `rx_s`.
    - If 1: load `data_out` from the shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data_out` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE:
    - Stay until `rx_s == 1`, then go to IDLE.
    - This prevents a held-low break from being decoded as repeated 0x00 frames.
- Counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Resets to 0 on every sample point; it never wraps.
  - Bit index width is `$clog2(DATA_BITS)+1`.
- `valid` and `frame_err` are never high in the same cycle.
- A new start bit is accepted the cycle after returning to IDLE. Back-to-back frames with a single stop bit therefore decode without loss.

## Timing
- Reset values:
  - `data_out` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0.
  - State = IDLE; shift register, counter and index = 0.
- Reset mid-frame:
  - The frame is aborted and returns to IDLE on the next edge.
  - No `valid` or `frame_err` is produced.
  - `data_out` returns to 0.
- Latency:
  - Let T0 be the first clock edge that registers `rx` low in synchronizer flop 1.
  - `busy` rises at T0+2.
  - `valid` (or `frame_err`) is high for exactly one cycle at T0 + 2 + `CLKS_PER_BIT/2` + `(DATA_BITS+1)*CLKS_PER_BIT`, ±1 cycle.
  - With defaults this is T0+154 ±1.
- `data_out` changes in the same cycle `valid` rises and is stable at least until the next `valid`.
- Glitches on `rx` shorter than `CLKS_PER_BIT/2 - 2` cycles produce no output, only a transient `busy` pulse.
- All outputs are registered; there are no combinational paths from `rx`.

## Test plan
- **Single frame:** send 0x55 at `CLKS_PER_BIT` = 16 (start 0, LSB first, stop 1).
  - Expect exactly one `valid` pulse with `data_out` = 0x55, `data_out[3:0]` = 0x5.
  - Expect `frame_err` never high and `busy` low afterwards.
- **Back-to-back frames:** send 0xA5, 0x0F, 0xF0 with no idle gap.
  - Expect three `valid` pulses spaced exactly 160 cycles apart, with `data_out` = 0xA5, then 0x0F, then 0xF0.
- **False start:** drive `rx` low for 4 cycles, then high.
  - Expect no `valid`, no `frame_err`, and `busy` back to 0 within 12 cycles.
  - `data_out` keeps its previous value.
- **Framing error:** after a good 0x3C, send 0x99 with the stop bit low, then hold `rx` low for 40 more cycles, then high.
  - Expect one `frame_err` pulse, no `valid`, and `data_out` remaining 0x3C.
  - Expect no further strobes until a new frame.
  - A following 0x12 frame decodes correctly.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of a 0xFF frame.
  - Expect no strobe from that frame and `data_out` = 0 after reset.
  - The next 0x5A frame yields `valid` with 0x5A.
- **Parameter sweep:** repeat the single-frame test with `CLKS_PER_BIT` = 4 and 434.
  - Expect identical data and latency matching the formula in Timing.
